// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch-stage types and default sizing.
package inst_fetch_pkg;
    typedef logic        Bit_t;
    typedef logic [31:0] InstAddr_t;
    typedef logic [31:0] Inst_t;

    localparam int IF_BUF_DEPTH = 4;
    localparam int IF_MAX_OUTST = 2;

    typedef struct packed {
        InstAddr_t pc;
        Inst_t     inst;
        Bit_t      filled;
    } FetchEntry_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// inst_fetch_fifo: in-order fetch buffer; entries are allocated at issue and
// filled later in allocation order through a separate fill pointer.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = IF_BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [31:0]            push_pc,
    input  logic                   fill,
    input  logic [31:0]            fill_inst,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_filled,
    output logic [31:0]            head_pc,
    output logic [31:0]            head_inst
);
    localparam int AW = $clog2(DEPTH);

    FetchEntry_t r_mem [DEPTH];
    logic [AW:0] r_head, r_tail, r_fptr;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fptr <= '0;
            if (!rst)
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (push) begin
                r_mem[r_tail[AW-1:0]] <= '{pc: push_pc, inst: '0, filled: 1'b0};
                r_tail <= r_tail + 1'b1;
            end
            // fill never targets the tail slot: a response implies an older unfilled entry
            if (fill) begin
                r_mem[r_fptr[AW-1:0]].inst   <= fill_inst;
                r_mem[r_fptr[AW-1:0]].filled <= 1'b1;
                r_fptr <= r_fptr + 1'b1;
            end
            if (pop)
                r_head <= r_head + 1'b1;
        end
    end

    assign count       = r_tail - r_head;
    assign head_filled = r_mem[r_head[AW-1:0]].filled;
    assign head_pc     = r_mem[r_head[AW-1:0]].pc;
    assign head_inst   = r_mem[r_head[AW-1:0]].inst;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: issues one imem read per PC, pairs responses with their PC and
// hands {pc, inst} to decode; flush drops buffered entries and owed responses.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH     = IF_BUF_DEPTH,
    parameter int MAX_OUTST = IF_MAX_OUTST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_ce,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        stall_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [OW-1:0] r_outst, r_discard;
    logic [CW-1:0] w_count;
    logic          w_head_filled, w_credit, w_issue, w_rsp, w_fill, w_pop;

    assign w_credit  = (w_count < CW'(DEPTH)) && (r_outst < OW'(MAX_OUTST));
    assign imem_req  = rst & pc_ce & w_credit & ~flush;
    assign imem_addr = pc;
    assign w_issue   = imem_req & imem_gnt;
    assign stall_pc  = pc_ce & ~w_issue;
    // a response with nothing outstanding is a protocol error and is ignored
    assign w_rsp     = imem_rvalid && (r_outst != '0);
    assign w_fill    = w_rsp && (r_discard == '0) && !flush;
    assign id_valid  = (w_count != '0) && w_head_filled;
    assign w_pop     = id_valid & id_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_outst   <= r_outst + OW'(w_issue) - OW'(w_rsp);
            // on flush every response still owed after this cycle must be dropped
            r_discard <= flush ? r_outst - OW'(w_rsp)
                               : r_discard - OW'(w_rsp && (r_discard != '0));
        end
    end

    inst_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (w_issue),
        .push_pc    (pc),
        .fill       (w_fill),
        .fill_inst  (imem_rdata),
        .pop        (w_pop),
        .count      (w_count),
        .head_filled(w_head_filled),
        .head_pc    (id_pc),
        .head_inst  (id_inst)
    );

    a_rsp_owed: assert property (@(posedge clk) disable iff (!rst) imem_rvalid |-> r_outst != '0);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and random stimulus checked against a queue-based
// model of the fetch buffer plus an in-order memory model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int DEPTH = IF_BUF_DEPTH;
    localparam int MAXO  = IF_MAX_OUTST;

    logic        clk = 1'b0, rst = 1'b0, pc_ce = 1'b0, flush = 1'b0;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b0;
    logic [31:0] pc = '0, imem_rdata = '0;
    logic [31:0] imem_addr, id_pc, id_inst;
    logic        stall_pc, imem_req, id_valid;

    int n_cmp = 0, n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] mem_q[$];
    int          m_outst = 0, m_disc = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_ce      (pc_ce),
        .pc         (pc),
        .flush      (flush),
        .stall_pc   (stall_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_ready   (id_ready)
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic pce, input logic fl, input logic g,
                        input logic rv, input logic rdy, input logic [31:0] tgt);
        logic        e_req, e_val, iss, rsp, pop, done;
        logic [31:0] w;
        rst         = r;
        pc_ce       = pce;
        flush       = fl;
        imem_gnt    = g;
        id_ready    = rdy;
        imem_rvalid = r && rv && (mem_q.size() > 0);
        imem_rdata  = imem_rvalid ? mw(mem_q[0]) : 32'h0;
        #2;
        e_req = r && pce && !fl && (m_q.size() < DEPTH) && (m_outst < MAXO);
        e_val = (m_q.size() > 0) && m_q[0].filled;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("stall_pc", 32'(stall_pc), 32'(pce && !(e_req && g)));
        chk("id_valid", 32'(id_valid), 32'(e_val));
        chk("imem_addr", imem_addr, pc);
        if (e_val) begin
            chk("id_pc", id_pc, m_q[0].pc);
            chk("id_inst", id_inst, m_q[0].inst);
        end
        iss = e_req && g;
        rsp = imem_rvalid;
        w   = imem_rdata;
        pop = e_val && rdy && !fl;
        @(posedge clk);
        if (!r) begin
            m_q.delete();
            mem_q.delete();
            m_outst = 0;
            m_disc  = 0;
        end else begin
            if (rsp) void'(mem_q.pop_front());
            if (iss) mem_q.push_back(pc);
            if (fl) begin
                m_q.delete();
                m_disc = m_outst - int'(rsp);
            end else begin
                if (pop) void'(m_q.pop_front());
                if (rsp && m_disc > 0) m_disc--;
                else if (rsp) begin
                    done = 1'b0;
                    foreach (m_q[i])
                        if (!done && !m_q[i].filled) begin
                            m_q[i].inst   = w;
                            m_q[i].filled = 1'b1;
                            done = 1'b1;
                        end
                end
                if (iss) m_q.push_back('{pc: pc, inst: 32'h0, filled: 1'b0});
            end
            m_outst += int'(iss) - int'(rsp);
        end
        #1;
        if (fl) pc = tgt;
        else if (iss) pc = pc + 32'd4;
    endtask

    initial begin
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        // streaming
        pc = 32'h0;
        repeat (12) step(1, 1, 0, 1, 1, 1, 0);
        // back-pressure then a single pop
        repeat (8) step(1, 1, 0, 1, 1, 0, 0);
        step(1, 1, 0, 1, 1, 1, 0);
        repeat (3) step(1, 1, 0, 1, 1, 0, 0);
        // grant delay at 0x40
        repeat (10) step(1, 0, 0, 0, 1, 1, 0);
        pc = 32'h40;
        repeat (3) step(1, 1, 0, 0, 1, 1, 0);
        repeat (6) step(1, 1, 0, 1, 1, 1, 0);
        // flush with two outstanding
        repeat (4) step(1, 0, 0, 0, 1, 1, 0);
        repeat (2) step(1, 1, 0, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0, 1, 32'h100);
        repeat (10) step(1, 1, 0, 1, 1, 1, 0);
        // flush coinciding with response and pop
        step(1, 1, 1, 1, 1, 1, 32'h200);
        repeat (8) step(1, 1, 0, 1, 1, 1, 0);
        // reset with a full buffer
        repeat (8) step(1, 1, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("rst6_id_valid", 32'(id_valid), 32'h0);
        chk("rst6_id_pc", id_pc, 32'h0);
        // random
        pc = 32'h1000;
        repeat (400)
            step(1, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, 32'($urandom_range(0, 1023)) << 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
